// File: rtl/bus_arbiter_mem_if.sv
// Cache-bus bundle between the per-core data caches (master) and the
// arbitrating memory responder (slave).
interface bus_arbiter_mem_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]    requestIn;
  logic [NUM_MASTERS-1:0]    writeFlagIn;
  logic [32*NUM_MASTERS-1:0] addrIn;
  logic [32*NUM_MASTERS-1:0] dataIn;
  logic [NUM_MASTERS-1:0]    interveneFlagIn;
  logic [NUM_MASTERS-1:0]    grantOut;
  logic [31:0]               dataOut;
  logic                      ackOut;
  logic [31:0]               addrOutSnooping;
  logic [NUM_MASTERS-1:0]    masterFlagSnooping;
  logic                      invalidateFlagOut;

  modport master (
    output requestIn, writeFlagIn, addrIn, dataIn, interveneFlagIn,
    input  grantOut, dataOut, ackOut, addrOutSnooping, masterFlagSnooping,
           invalidateFlagOut
  );

  modport slave (
    input  requestIn, writeFlagIn, addrIn, dataIn, interveneFlagIn,
    output grantOut, dataOut, ackOut, addrOutSnooping, masterFlagSnooping,
           invalidateFlagOut
  );
endinterface

// File: rtl/bus_arbiter_mem.sv
// Round-robin cache-bus arbiter with snoop broadcast, cache-to-cache
// intervention and a fixed-latency single-word backing memory.
module bus_arbiter_mem #(
  parameter int NUM_MASTERS = 2,
  parameter int MEM_WORDS   = 1024,
  parameter int MEM_LATENCY = 4
) (
  input  logic             clk,
  input  logic             resetN,
  bus_arbiter_mem_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int AW    = $clog2(MEM_WORDS);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, SNOOP, ACCESS, DONE} state_t;

  state_t                 state, stateNext;
  logic [IDX_W-1:0]       ptr, ptrNext;
  logic [CNT_W-1:0]       cnt, cntNext;
  logic [NUM_MASTERS-1:0] grant, grantNext;
  logic [31:0]            addrReg, addrNext;
  logic [31:0]            dataReg, dataRegNext;
  logic [31:0]            rdData, rdDataNext;
  logic                   writeReg, writeNext;
  logic                   ack, ackNext;
  logic                   memWe;
  logic [AW-1:0]          memIdx;
  logic [31:0]            mem [MEM_WORDS];

  logic                   found;
  logic [IDX_W-1:0]       winIdx;
  logic [NUM_MASTERS-1:0] ivMask;
  logic                   ivFound;
  logic [31:0]            ivData;
  int                     cand;

  assign memIdx = addrReg[AW+1:2];

  // Round-robin search starting at ptr, plus lowest-index intervener
  // excluding the current winner.
  always_comb begin
    found   = 1'b0;
    winIdx  = '0;
    cand    = 0;
    ivFound = 1'b0;
    ivData  = '0;
    ivMask  = bus.interveneFlagIn & ~grant;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (int'(ptr) + i) % NUM_MASTERS;
      if (!found && bus.requestIn[cand]) begin
        found  = 1'b1;
        winIdx = IDX_W'(cand);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!ivFound && ivMask[i]) begin
        ivFound = 1'b1;
        ivData  = bus.dataIn[32*i +: 32];
      end
    end
  end

  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stateNext   = state;
    ptrNext     = ptr;
    cntNext     = cnt;
    grantNext   = grant;
    addrNext    = addrReg;
    dataRegNext = dataReg;
    rdDataNext  = rdData;
    writeNext   = writeReg;
    ackNext     = ack;
    memWe       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grantNext         = '0;
          grantNext[winIdx] = 1'b1;
          ptrNext     = (winIdx == IDX_W'(NUM_MASTERS - 1)) ? '0 : winIdx + 1'b1;
          addrNext    = bus.addrIn[32*winIdx +: 32];
          dataRegNext = bus.dataIn[32*winIdx +: 32];
          writeNext   = bus.writeFlagIn[winIdx];
          stateNext   = SNOOP;
        end
      end
      SNOOP: begin
        if (!writeReg && ivFound) begin
          rdDataNext = ivData;
          ackNext    = 1'b1;
          stateNext  = DONE;
        end else begin
          cntNext   = CNT_W'(MEM_LATENCY - 1);
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cntNext = cnt - 1'b1;
        end else begin
          memWe = writeReg;
          if (!writeReg) rdDataNext = mem[memIdx];
          ackNext   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        ackNext   = 1'b0;
        grantNext = '0;
        addrNext  = '0;
        writeNext = 1'b0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      grant    <= '0;
      addrReg  <= '0;
      dataReg  <= '0;
      rdData   <= '0;
      writeReg <= 1'b0;
      ack      <= 1'b0;
    end else begin
      state    <= stateNext;
      ptr      <= ptrNext;
      cnt      <= cntNext;
      grant    <= grantNext;
      addrReg  <= addrNext;
      dataReg  <= dataRegNext;
      rdData   <= rdDataNext;
      writeReg <= writeNext;
      ack      <= ackNext;
    end
  end

  // NOTE: the memory array has no reset so it maps onto RAM; an async
  // reset drops state to IDLE and thereby kills memWe immediately.
  always_ff @(posedge clk) begin
    if (memWe) mem[memIdx] <= dataReg;
  end

  assign bus.grantOut           = grant;
  assign bus.masterFlagSnooping = grant;
  assign bus.dataOut            = rdData;
  assign bus.ackOut             = ack;
  assign bus.addrOutSnooping    = addrReg;
  assign bus.invalidateFlagOut  = writeReg;
endmodule

// File: tb/tb_bus_arbiter_mem.sv
// Self-checking bench for bus_arbiter_mem: vector table through a
// scoreboard, plus round-robin and mid-transaction reset sequences.
module tb_bus_arbiter_mem;
  localparam int NM  = 2;
  localparam int LAT = 4;

  typedef struct {
    int          m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  iv;
    logic [31:0] ivData;
    logic [31:0] expData;
    int          lat;
  } vec_t;

  typedef struct {
    int          m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic clk;
  logic resetN;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[11];

  bus_arbiter_mem_if #(.NUM_MASTERS(NM)) bus ();

  bus_arbiter_mem #(
    .NUM_MASTERS(NM),
    .MEM_WORDS  (1024),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NM-1:0] oneHot(input int m);
    logic [NM-1:0] v;
    v    = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  task automatic clearInputs();
    bus.requestIn       = '0;
    bus.writeFlagIn     = '0;
    bus.addrIn          = '0;
    bus.dataIn          = '0;
    bus.interveneFlagIn = '0;
  endtask

  task automatic runTxn(input vec_t v);
    int   cyc;
    exp_t e;
    @(negedge clk);
    bus.requestIn               = '0;
    bus.requestIn[v.m]          = 1'b1;
    bus.writeFlagIn[v.m]        = v.wr;
    bus.addrIn[32*v.m +: 32]    = v.addr;
    bus.dataIn[32*v.m +: 32]    = v.data;
    sb.push_back('{v.m, v.wr, v.addr, v.expData, v.lat});
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.grantOut == '0 && cyc < 20);
    check("grantLatency", 64'(cyc), 64'd1);
    check("grantOneHot", 64'(bus.grantOut), 64'(oneHot(v.m)));
    check("invalidate", 64'(bus.invalidateFlagOut), 64'(v.wr));
    check("snoopAddr", 64'(bus.addrOutSnooping), 64'(v.addr));
    bus.requestIn = '0;
    for (int i = 0; i < NM; i++)
      if (v.iv[i] && i != v.m) bus.dataIn[32*i +: 32] = v.ivData;
    bus.interveneFlagIn = v.iv;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.ackOut && cyc < 40);
    bus.interveneFlagIn = '0;
    if (sb.size() == 0) begin
      check("scoreboardEmpty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("ackLatency", 64'(cyc), 64'(e.lat));
      check("doneGrant", 64'(bus.grantOut), 64'(oneHot(e.m)));
      check("doneAddr", 64'(bus.addrOutSnooping), 64'(e.addr));
      if (!e.wr) check("readData", 64'(bus.dataOut), 64'(e.data));
    end
    @(negedge clk);
    check("idleAfterAck", {bus.ackOut, bus.invalidateFlagOut, 30'd0, bus.addrOutSnooping},
          64'd0);
    check("idleGrant", 64'(bus.grantOut), 64'd0);
  endtask

  initial begin
    int   cyc, acks, zeroRun, grants;
    logic sawAck;
    logic [NM-1:0] prevGrant;
    exp_t e;

    // {master, write, addr, data, intervene, interveneData, expected read, latency}
    vecs[0]  = '{1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 32'h0,         32'h0,         2 + LAT};
    vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         2'b00, 32'h0,         32'hDEAD_BEEF, 2 + LAT};
    vecs[2]  = '{1, 1'b1, 32'h0000_0020, 32'h1234_5678, 2'b00, 32'h0,         32'h0,         2 + LAT};
    vecs[3]  = '{0, 1'b0, 32'h0000_0020, 32'h0,         2'b00, 32'h0,         32'h1234_5678, 2 + LAT};
    vecs[4]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         2'b10, 32'hCAFE_F00D, 32'hCAFE_F00D, 2};
    vecs[5]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         2'b01, 32'h1111_1111, 32'hDEAD_BEEF, 2 + LAT};
    vecs[6]  = '{0, 1'b1, 32'h0000_0030, 32'hAAAA_5555, 2'b10, 32'h7777_7777, 32'h0,         2 + LAT};
    vecs[7]  = '{1, 1'b0, 32'h0000_0030, 32'h0,         2'b00, 32'h0,         32'hAAAA_5555, 2 + LAT};
    vecs[8]  = '{1, 1'b0, 32'h0000_1030, 32'h0,         2'b00, 32'h0,         32'hAAAA_5555, 2 + LAT};
    vecs[9]  = '{0, 1'b0, 32'h0000_0033, 32'h0,         2'b00, 32'h0,         32'hAAAA_5555, 2 + LAT};
    vecs[10] = '{1, 1'b0, 32'h0000_0020, 32'h0,         2'b01, 32'h0BAD_F00D, 32'h0BAD_F00D, 2};

    clearInputs();
    resetN = 1'b0;
    #22;
    check("rstGrant", 64'(bus.grantOut), 64'd0);
    check("rstAck", 64'(bus.ackOut), 64'd0);
    check("rstData", 64'(bus.dataOut), 64'd0);
    check("rstAddr", 64'(bus.addrOutSnooping), 64'd0);
    check("rstInval", 64'(bus.invalidateFlagOut), 64'd0);
    @(negedge clk);
    resetN = 1'b1;

    foreach (vecs[i]) runTxn(vecs[i]);

    // Round robin: both masters request continuously after a fresh reset.
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    bus.addrIn[31:0]  = 32'h0000_0010;
    bus.addrIn[63:32] = 32'h0000_0020;
    bus.writeFlagIn   = '0;
    for (int k = 0; k < 4; k++)
      sb.push_back('{k % 2, 1'b0, 32'h0, (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678, 0});
    bus.requestIn = 2'b11;
    acks = 0; zeroRun = 0; grants = 0; prevGrant = '0; cyc = 0;
    while (acks < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.grantOut != '0 && bus.grantOut != 2'b01 && bus.grantOut != 2'b10)
        check("rrOverlap", 64'(bus.grantOut), 64'd0);
      if (bus.grantOut == '0) zeroRun++;
      else if (prevGrant == '0) begin
        if (grants > 0) check("rrGap", 64'(zeroRun), 64'd1);
        grants++;
        zeroRun = 0;
      end
      prevGrant = bus.grantOut;
      if (bus.ackOut) begin
        acks++;
        if (acks == 4) bus.requestIn = '0;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rrOrder", 64'(bus.grantOut), 64'(oneHot(e.m)));
          check("rrData", 64'(bus.dataOut), 64'(e.data));
        end
      end
    end
    check("rrAcks", 64'(acks), 64'd4);
    @(negedge clk);
    check("rrIdle", 64'(bus.grantOut), 64'd0);

    // Reset in the middle of a write's ACCESS phase.
    clearInputs();
    @(negedge clk);
    bus.requestIn[1]     = 1'b1;
    bus.writeFlagIn[1]   = 1'b1;
    bus.addrIn[63:32]    = 32'h0000_0020;
    bus.dataIn[63:32]    = 32'hFFFF_FFFF;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.grantOut == '0 && cyc < 20);
    check("rstTxnGrant", 64'(bus.grantOut), 64'd2);
    bus.requestIn = '0;
    repeat (2) @(negedge clk);
    #2;
    resetN = 1'b0;
    #1;
    check("midRstGrant", 64'(bus.grantOut), 64'd0);
    check("midRstInval", 64'(bus.invalidateFlagOut), 64'd0);
    check("midRstAddr", 64'(bus.addrOutSnooping), 64'd0);
    check("midRstAck", 64'(bus.ackOut), 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    clearInputs();
    sawAck = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ackOut) sawAck = 1'b1;
    end
    check("noAckAfterReset", 64'(sawAck), 64'd0);
    runTxn('{0, 1'b0, 32'h0000_0020, 32'h0, 2'b00, 32'h0, 32'h1234_5678, 2 + LAT});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_mem.md
Name: bus_arbiter_mem

Overview:
- Responder end of the cache bus: arbitrates `requestOutBus`/`grantInBus` handshakes from NUM_MASTERS data caches.
- Broadcasts the winning address on the snooping lines so other caches can invalidate or intervene.
- Services the single-word transfer from a backing memory array with fixed latency.
- Sits between the per-core dc instances and main memory; exactly one transaction is in flight at a time.

Parameters:
- NUM_MASTERS, 2: number of cache requesters (2..8).
- MEM_WORDS, 1024: backing memory depth in 32-bit words (power of two).
- MEM_LATENCY, 4: cycles of memory access after the snoop cycle (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous active-low reset.
- requestIn  input  NUM_MASTERS  per-master bus request (driven by `requestOutBus`).
- writeFlagIn  input  NUM_MASTERS  per-master: 1 = write, 0 = read; valid with request.
- addrIn  input  32*NUM_MASTERS  flattened per-master byte address; master i at [32i+31:32i].
- dataIn  input  32*NUM_MASTERS  flattened per-master write data or intervention data.
- interveneFlagIn  input  NUM_MASTERS  per-master: holds the snooped line and supplies the data.
- grantOut  output  NUM_MASTERS  one-hot grant (to `grantInBus`).
- dataOut  output  32  read data broadcast to all masters.
- ackOut  output  1  one-cycle transaction-complete strobe.
- addrOutSnooping  output  32  address of the current transaction.
- masterFlagSnooping  output  NUM_MASTERS  equals grantOut.
- invalidateFlagOut  output  1  current transaction is a write; non-masters invalidate.

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE; grantOut=0, ackOut=0, dataOut=0, addrOutSnooping=0, invalidateFlagOut=0.
  - Round-robin pointer=0, so master 0 has highest priority.
  - Memory array is not reset. Reset mid-transaction aborts it with no memory write and no ack.
- States: IDLE, SNOOP, ACCESS, DONE.
- IDLE:
  - If requestIn!=0, pick the winner by round robin: search from index ptr upward, wrapping at NUM_MASTERS.
  - On the next edge:
    - Latch winner index, addr, data and write flag.
    - Set grantOut to one-hot(winner) and ptr=(winner+1) mod NUM_MASTERS.
    - Drive addrOutSnooping=addr and invalidateFlagOut=write; go to SNOOP.
- SNOOP (exactly 1 cycle):
  - Sample interveneFlagIn with the winner's bit masked off.
  - Read with any intervener: capture dataIn of the lowest-index intervener into dataOut and go to DONE. Memory is not accessed.
  - Otherwise: counter=MEM_LATENCY-1 and go to ACCESS. Intervention is ignored on writes.
- ACCESS:
  - While counter!=0, decrement.
  - At 0, perform the access and go to DONE:
    - Read: dataOut=mem[addr[log2(MEM_WORDS)+1:2]].
    - Write: mem[...]=data.
- DONE (1 cycle):
  - ackOut=1; dataOut is valid for reads and unchanged by writes.
  - grantOut, addrOutSnooping and invalidateFlagOut stay asserted through DONE.
  - Next edge: all three clear, ackOut=0, state=IDLE.
- Latency: request sampled in IDLE at cycle t.
  - Grant is visible at t+1.
  - Ack at t+2 on intervention, else at t+2+MEM_LATENCY.
- Address bits above the memory index and addr[1:0] are ignored (word aliasing).
- requestIn changes after grant are ignored. The transaction always completes.
- A request still high in the IDLE cycle after ack is a new transaction. A master must drop requestIn in the ack cycle to avoid a repeat.
- Minimum gap between grants is one IDLE cycle. The arbiter never grants two masters at once.
- grantOut is never nonzero in IDLE.

Test Plan:
- Reset then single read:
  - Stimulus: master 0 reads addr 0x10 (mem[4]=0xDEADBEEF), MEM_LATENCY=4.
  - Response: grantOut=01 at t+1, ack at t+6 with dataOut=0xDEADBEEF, invalidateFlagOut=0.
- Write then read-back:
  - Stimulus: master 1 writes 0x12345678 to 0x20, then master 0 reads 0x20.
  - Response: invalidateFlagOut=1 during the write transaction; the read returns 0x12345678.
- Round robin:
  - Stimulus: both masters hold requests continuously.
  - Response: grant order 0,1,0,1; no grant overlap; one IDLE cycle between transactions.
- Intervention:
  - Stimulus: master 0 reads; master 1 raises interveneFlagIn in SNOOP with dataIn[63:32]=0xCAFEF00D.
  - Response: ack at t+2 with dataOut=0xCAFEF00D; memory is not read.
- Self-intervene masked, and write ignores intervention:
  - Stimulus: the winner's own intervene bit is set, or a non-master intervenes on a write.
  - Response: full memory latency path; memory updated on the write.
- Async reset mid-ACCESS:
  - Stimulus: a write is in progress when resetN pulses low.
  - Response: outputs clear immediately; no ack; the target word is unchanged on a subsequent read.
